// File: rtl/bf_weight_scheduler.sv
// Steps a flop-based beamforming weight table one packet at a time by snooping the
// multiplier input handshake. Optional BF_DWELL_EN adds cfg_dwell (packets per entry).
module bf_weight_scheduler #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_CH       = 4,
    parameter int TABLE_DEPTH  = 16,
    parameter int IDX_WIDTH    = 4
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic                                cfg_we,
    input  logic [IDX_WIDTH-1:0]                cfg_addr,
    input  logic [NUM_CH*(WEIGHT_WIDTH+1)-1:0]  cfg_wdata,
    input  logic [IDX_WIDTH:0]                  cfg_len,
    input  logic                                cfg_loop,
    input  logic [NUM_CH*(WEIGHT_WIDTH+1)-1:0]  cfg_default,
`ifdef BF_DWELL_EN
    input  logic [7:0]                          cfg_dwell,
`endif
    input  logic                                cfg_start,
    input  logic                                cfg_stop,
    input  logic                                s_tvalid,
    input  logic                                s_tready,
    input  logic                                s_tlast,
    output logic [NUM_CH*(WEIGHT_WIDTH+1)-1:0]  bweight,
    output logic [IDX_WIDTH-1:0]                cur_idx,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         sweep_cnt,
    output logic                                wr_err
);

    localparam int SET_W = NUM_CH * (WEIGHT_WIDTH + 1);
    localparam logic [IDX_WIDTH:0]   LEN_MAX = (IDX_WIDTH+1)'(TABLE_DEPTH);
    localparam logic [IDX_WIDTH:0]   LEN_ONE = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SET_W-1:0]       table_q [TABLE_DEPTH];
    logic [IDX_WIDTH:0]     len_q, len_d;
    logic                   loop_q, loop_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]       bweight_q, bweight_d;
    logic [15:0]            sweep_q, sweep_d;
    logic                   done_q, done_d;
    logic                   wr_err_q, wr_err_d;

    logic                   pb;
    logic                   busy_w;
    logic                   addr_ok;
    logic                   tbl_we;
    logic                   start_ok;
    logic                   at_last;
    logic                   dwell_done;
    logic                   finish;
    logic [IDX_WIDTH-1:0]   idx_nxt;
    logic [SET_W-1:0]       entry0;

    assign pb       = s_tvalid & s_tready & s_tlast;
    assign busy_w   = (state_q != S_IDLE);
    assign addr_ok  = ({1'b0, cfg_addr} < LEN_MAX);
    assign start_ok = cfg_start & ~cfg_stop & (cfg_len != '0);
    assign at_last  = ({1'b0, idx_q} == (len_q - LEN_ONE));
    assign idx_nxt  = idx_q + IDX_ONE;
    // A write to entry 0 in the start cycle must be visible to that same start.
    assign entry0   = (tbl_we && (cfg_addr == '0)) ? cfg_wdata : table_q[0];

`ifdef BF_DWELL_EN
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] dcnt_q, dcnt_d;

    assign dwell_done = ({1'b0, dcnt_q} + 9'd1) >= {1'b0, dwell_q};

    always_comb begin
        dwell_d = dwell_q;
        dcnt_d  = dcnt_q;
        if (state_q == S_IDLE) begin
            if (start_ok) begin
                dwell_d = (cfg_dwell == 8'd0) ? 8'd1 : cfg_dwell;
                dcnt_d  = '0;
            end
        end else if ((state_q == S_RUN) && !cfg_stop && pb) begin
            dcnt_d = dwell_done ? 8'd0 : (dcnt_q + 8'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            dwell_q <= '0;
            dcnt_q  <= '0;
        end else begin
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
        end
    end
`else
    assign dwell_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        loop_d    = loop_q;
        idx_d     = idx_q;
        bweight_d = bweight_q;
        sweep_d   = sweep_q;
        done_d    = 1'b0;
        wr_err_d  = 1'b0;
        tbl_we    = 1'b0;
        finish    = 1'b0;

        if (cfg_we) begin
            if (busy_w || !addr_ok) wr_err_d = 1'b1;
            else                    tbl_we   = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                bweight_d = cfg_default;
                idx_d     = '0;
                if (start_ok) begin
                    state_d   = S_RUN;
                    len_d     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                    loop_d    = cfg_loop;
                    bweight_d = entry0;
                    sweep_d   = '0;
                end
            end
            S_RUN: begin
                // A stop on a boundary ends the sweep there without advancing.
                if (cfg_stop) begin
                    if (pb) finish  = 1'b1;
                    else    state_d = S_STOPPING;
                end else if (pb && dwell_done) begin
                    if (!at_last) begin
                        idx_d     = idx_nxt;
                        bweight_d = table_q[idx_nxt];
                    end else if (loop_q) begin
                        idx_d     = '0;
                        bweight_d = table_q[0];
                        if (sweep_q != 16'hFFFF) sweep_d = sweep_q + 16'd1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_STOPPING: begin
                if (pb) finish = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            bweight_d = cfg_default;
            idx_d     = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
        end else if (tbl_we) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            loop_q    <= 1'b0;
            idx_q     <= '0;
            bweight_q <= '0;
            sweep_q   <= '0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            idx_q     <= idx_d;
            bweight_q <= bweight_d;
            sweep_q   <= sweep_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign bweight   = bweight_q;
    assign cur_idx   = idx_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign sweep_cnt = sweep_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_bf_weight_scheduler.sv
// Testbench for bf_weight_scheduler: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model of the scheduling rules.
module tb_bf_weight_scheduler;

    localparam int WW = 8;
    localparam int NC = 4;
    localparam int TD = 16;
    localparam int IW = 4;
    localparam int SW = NC * (WW + 1);

    logic          CLK = 1'b0;
    logic          resetn;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [SW-1:0] cfg_wdata;
    logic [IW:0]   cfg_len;
    logic          cfg_loop;
    logic [SW-1:0] cfg_default;
`ifdef BF_DWELL_EN
    logic [7:0]    cfg_dwell;
`endif
    logic          cfg_start, cfg_stop;
    logic          s_tvalid, s_tready, s_tlast;
    logic [SW-1:0] bweight;
    logic [IW-1:0] cur_idx;
    logic          busy, done, wr_err;
    logic [15:0]   sweep_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    bf_weight_scheduler #(
        .WEIGHT_WIDTH(WW), .NUM_CH(NC), .TABLE_DEPTH(TD), .IDX_WIDTH(IW)
    ) dut (
        .CLK(CLK), .resetn(resetn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_len(cfg_len), .cfg_loop(cfg_loop), .cfg_default(cfg_default),
`ifdef BF_DWELL_EN
        .cfg_dwell(cfg_dwell),
`endif
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .bweight(bweight), .cur_idx(cur_idx), .busy(busy), .done(done),
        .sweep_cnt(sweep_cnt), .wr_err(wr_err)
    );

    // Reference model: mode 0 idle, 1 sweeping, 2 waiting for boundary to stop.
    int            m_mode, m_len, m_idx, m_sweep, m_dwell, m_hits;
    bit            m_loop, m_done, m_werr;
    logic [SW-1:0] m_bw;
    logic [SW-1:0] m_tab [TD];

    function automatic logic [SW-1:0] rep(logic [WW:0] w);
        return {NC{w}};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_idx = 0; m_sweep = 0; m_dwell = 1; m_hits = 0;
        m_loop = 0; m_done = 0; m_werr = 0; m_bw = '0;
        for (int i = 0; i < TD; i++) m_tab[i] = '0;
    endtask

    task automatic model_end();
        m_mode = 0; m_done = 1; m_bw = cfg_default; m_idx = 0;
    endtask

    task automatic model_step();
        bit pb;
        pb = s_tvalid && s_tready && s_tlast;
        m_done = 0;
        m_werr = 0;
        if (!resetn) begin
            model_reset();
            return;
        end
        if (cfg_we) begin
            if (m_mode != 0) m_werr = 1;
            else             m_tab[cfg_addr] = cfg_wdata;
        end
        case (m_mode)
            0: begin
                m_bw  = cfg_default;
                m_idx = 0;
                if (cfg_start && !cfg_stop && cfg_len != 0) begin
                    m_len   = (int'(cfg_len) > TD) ? TD : int'(cfg_len);
                    m_loop  = cfg_loop;
                    m_bw    = m_tab[0];
                    m_sweep = 0;
                    m_hits  = 0;
`ifdef BF_DWELL_EN
                    m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
`else
                    m_dwell = 1;
`endif
                    m_mode  = 1;
                end
            end
            1: begin
                if (cfg_stop && pb) model_end();
                else if (cfg_stop) m_mode = 2;
                else if (pb) begin
                    m_hits++;
                    if (m_hits >= m_dwell) begin
                        m_hits = 0;
                        if (m_idx < m_len - 1) begin
                            m_idx++;
                            m_bw = m_tab[m_idx];
                        end else if (m_loop) begin
                            m_idx = 0;
                            m_bw  = m_tab[0];
                            if (m_sweep < 65535) m_sweep++;
                        end else begin
                            model_end();
                        end
                    end
                end
            end
            default: if (pb) model_end();
        endcase
    endtask

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".bweight"}, 64'(bweight),   64'(m_bw));
        chk({tag, ".cur_idx"}, 64'(cur_idx),   64'(m_idx));
        chk({tag, ".busy"},    64'(busy),      64'(m_mode != 0));
        chk({tag, ".done"},    64'(done),      64'(m_done));
        chk({tag, ".sweep"},   64'(sweep_cnt), 64'(m_sweep));
        chk({tag, ".wr_err"},  64'(wr_err),    64'(m_werr));
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_start = 0; cfg_stop = 0;
        s_tvalid = 0; s_tready = 0; s_tlast = 0;
    endtask

    task automatic pkt(int n, string tag);
        for (int b = 0; b < n; b++) begin
            s_tvalid = 1; s_tready = 1; s_tlast = (b == n - 1);
            step();
            check_model(tag);
        end
        s_tvalid = 0; s_tready = 0; s_tlast = 0;
    endtask

    task automatic start(int len, bit loop);
        cfg_start = 1; cfg_len = 5'(len); cfg_loop = loop;
        step();
        check_model("start");
        cfg_start = 0;
    endtask

    typedef struct {
        bit       we;
        bit [3:0] addr;
        bit [8:0] wd;
        bit       st;
        bit       sp;
        bit [4:0] len;
        bit       lp;
        bit [2:0] beat;
        bit [8:0] e_bw;
        bit [3:0] e_idx;
        bit       e_busy;
        bit       e_done;
    } vec_t;

    function automatic vec_t mk(bit we, bit [3:0] a, bit [8:0] wd, bit st, bit sp,
                                bit [4:0] ln, bit lp, bit [2:0] bt,
                                bit [8:0] ebw, bit [3:0] eix, bit eb, bit ed);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.st = st; v.sp = sp; v.len = ln; v.lp = lp;
        v.beat = bt; v.e_bw = ebw; v.e_idx = eix; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        // beat = {tvalid, tready, tlast}
        vt.push_back(mk(1, 0, 9'h010, 0, 0, 0, 0, 3'b000, 9'h1AA, 0, 0, 0));
        vt.push_back(mk(1, 1, 9'h020, 0, 0, 0, 0, 3'b000, 9'h1AA, 0, 0, 0));
        vt.push_back(mk(1, 2, 9'h040, 0, 0, 0, 0, 3'b000, 9'h1AA, 0, 0, 0));
        vt.push_back(mk(0, 0, 9'h000, 1, 0, 3, 0, 3'b000, 9'h010, 0, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h010, 0, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h010, 0, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h010, 0, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b111, 9'h020, 1, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b101, 9'h020, 1, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h020, 1, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h020, 1, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b111, 9'h040, 2, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b011, 9'h040, 2, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b110, 9'h040, 2, 1, 0));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b111, 9'h1AA, 0, 0, 1));
        vt.push_back(mk(0, 0, 9'h000, 0, 0, 0, 0, 3'b000, 9'h1AA, 0, 0, 0));
        vt.push_back(mk(0, 0, 9'h000, 1, 0, 0, 0, 3'b000, 9'h1AA, 0, 0, 0));
        vt.push_back(mk(0, 0, 9'h000, 1, 1, 3, 0, 3'b000, 9'h1AA, 0, 0, 0));

        clr();
        cfg_len = '0; cfg_loop = 0; cfg_default = rep(9'h1AA);
`ifdef BF_DWELL_EN
        cfg_dwell = 8'd1;
`endif
        resetn = 0;
        step();
        step();
        chk("reset.bweight", 64'(bweight), 64'd0);
        chk("reset.cur_idx", 64'(cur_idx), 64'd0);
        chk("reset.busy",    64'(busy),    64'd0);
        chk("reset.done",    64'(done),    64'd0);
        chk("reset.sweep",   64'(sweep_cnt), 64'd0);
        chk("reset.wr_err",  64'(wr_err),  64'd0);
        resetn = 1;

        foreach (vt[i]) begin
            cfg_we = vt[i].we; cfg_addr = vt[i].addr; cfg_wdata = rep(vt[i].wd);
            cfg_start = vt[i].st; cfg_stop = vt[i].sp; cfg_len = vt[i].len;
            cfg_loop = vt[i].lp;
            {s_tvalid, s_tready, s_tlast} = vt[i].beat;
            step();
            chk($sformatf("vec%0d.bweight", i), 64'(bweight), 64'(rep(vt[i].e_bw)));
            chk($sformatf("vec%0d.cur_idx", i), 64'(cur_idx), 64'(vt[i].e_idx));
            chk($sformatf("vec%0d.busy", i),    64'(busy),    64'(vt[i].e_busy));
            chk($sformatf("vec%0d.done", i),    64'(done),    64'(vt[i].e_done));
        end
        clr();

        // Continuous loop, 7 packets.
        start(3, 1);
        for (int p = 0; p < 7; p++) pkt(4, "loop");
        chk("loop.sweep", 64'(sweep_cnt), 64'd2);
        chk("loop.busy",  64'(busy),      64'd1);
        chk("loop.idx",   64'(cur_idx),   64'd1);
        cfg_stop = 1; step(); check_model("loop.stopreq"); cfg_stop = 0;
        pkt(2, "loop.drain");
        chk("loop.done", 64'(done), 64'd1);
        chk("loop.bw",   64'(bweight), 64'(rep(9'h1AA)));

        // Stop requested mid packet 2.
        start(3, 0);
        pkt(4, "stop.p1");
        s_tvalid = 1; s_tready = 1; s_tlast = 0;
        step(); check_model("stop.b0");
        cfg_stop = 1;
        step(); check_model("stop.b1");
        cfg_stop = 0;
        chk("stop.held",  64'(bweight), 64'(rep(9'h020)));
        chk("stop.busy",  64'(busy), 64'd1);
        step(); check_model("stop.b2");
        s_tlast = 1;
        step(); check_model("stop.b3");
        clr();
        chk("stop.done", 64'(done), 64'd1);
        chk("stop.idx",  64'(cur_idx), 64'd0);
        chk("stop.bw",   64'(bweight), 64'(rep(9'h1AA)));
        step(); check_model("stop.after");

        // Writes and starts while busy are rejected.
        start(3, 1);
        cfg_we = 1; cfg_addr = 4'd1; cfg_wdata = rep(9'h1FF);
        cfg_start = 1; cfg_len = 5'd2;
        step(); check_model("busy.we");
        clr();
        chk("busy.wr_err", 64'(wr_err), 64'd1);
        step(); check_model("busy.idle");
        chk("busy.wr_err_clr", 64'(wr_err), 64'd0);
        pkt(3, "busy.p");
        chk("busy.entry1", 64'(bweight), 64'(rep(9'h020)));
        pkt(3, "busy.p"); pkt(3, "busy.p"); pkt(3, "busy.p");
        chk("busy.entry1_pass2", 64'(bweight), 64'(rep(9'h020)));
        cfg_stop = 1; pkt(1, "busy.end"); clr();
        chk("busy.done", 64'(done), 64'd1);

        // Write to entry 0 in the start cycle; zero-length start.
        cfg_we = 1; cfg_addr = 4'd0; cfg_wdata = rep(9'h0AB);
        start(1, 0);
        clr();
        chk("wstart.bw", 64'(bweight), 64'(rep(9'h0AB)));
        pkt(2, "wstart.p");
        chk("wstart.done", 64'(done), 64'd1);
        start(0, 0);
        chk("len0.busy", 64'(busy), 64'd0);

        // Length clamps to the table depth.
        for (int i = 0; i < TD; i++) begin
            cfg_we = 1; cfg_addr = 4'(i); cfg_wdata = rep(9'(i * 3 + 1));
            step(); check_model("clamp.wr");
        end
        clr();
        start(20, 1);
        for (int p = 0; p < TD; p++) begin
            pkt(1, "clamp.p");
            if (p == TD - 2) chk("clamp.idx15", 64'(cur_idx), 64'd15);
        end
        chk("clamp.wrap_idx", 64'(cur_idx), 64'd0);
        chk("clamp.sweep",    64'(sweep_cnt), 64'd1);
        chk("clamp.bw",       64'(bweight), 64'(rep(9'h001)));
        cfg_stop = 1; pkt(1, "clamp.end"); clr();

        // Reset in the middle of a sweep.
        start(3, 1);
        pkt(2, "rst.p"); pkt(2, "rst.p");
        resetn = 0;
        step();
        chk("rst.bweight", 64'(bweight), 64'd0);
        chk("rst.idx",     64'(cur_idx), 64'd0);
        chk("rst.busy",    64'(busy),    64'd0);
        chk("rst.done",    64'(done),    64'd0);
        chk("rst.sweep",   64'(sweep_cnt), 64'd0);
        resetn = 1;
        step(); check_model("rst.idle");
        chk("rst.default", 64'(bweight), 64'(rep(9'h1AA)));
        start(2, 0);
        chk("rst.table_clear", 64'(bweight), 64'd0);
        pkt(1, "rst.p"); pkt(1, "rst.p");

`ifdef BF_DWELL_EN
        cfg_we = 1; cfg_addr = 4'd0; cfg_wdata = rep(9'h011); step(); check_model("dw.wr");
        cfg_addr = 4'd1; cfg_wdata = rep(9'h022); step(); check_model("dw.wr");
        clr();
        cfg_dwell = 8'd3;
        start(2, 0);
        pkt(1, "dw.p"); pkt(1, "dw.p");
        chk("dw.idx_hold", 64'(cur_idx), 64'd0);
        pkt(1, "dw.p");
        chk("dw.idx_adv", 64'(cur_idx), 64'd1);
        chk("dw.bw_adv",  64'(bweight), 64'(rep(9'h022)));
        pkt(1, "dw.p"); pkt(1, "dw.p"); pkt(1, "dw.p");
        chk("dw.done", 64'(done), 64'd1);
        cfg_dwell = 8'd0;
        start(2, 0);
        pkt(1, "dw0.p");
        chk("dw0.idx", 64'(cur_idx), 64'd1);
        pkt(1, "dw0.p");
        chk("dw0.done", 64'(done), 64'd1);
`endif

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            resetn    = ($urandom_range(0, 199) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 4'($urandom_range(0, 15));
            cfg_wdata = SW'({$urandom(), $urandom()});
            cfg_start = ($urandom_range(0, 11) == 0);
            cfg_stop  = ($urandom_range(0, 39) == 0);
            cfg_len   = 5'($urandom_range(0, 20));
            cfg_loop  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) cfg_default = SW'({$urandom(), $urandom()});
`ifdef BF_DWELL_EN
            cfg_dwell = 8'($urandom_range(0, 3));
`endif
            s_tvalid  = ($urandom_range(0, 3) != 0);
            s_tready  = ($urandom_range(0, 3) != 0);
            s_tlast   = ($urandom_range(0, 2) == 0);
            step();
            check_model("rnd");
        end
        clr();
        resetn = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bf_weight_scheduler.md
Name: bf_weight_scheduler

Overview:
- Sequences beamforming weights into the AXI-stream multiplier lanes. Weights change only on packet boundaries, so every packet is scaled by one coherent weight set.
- Holds a per-entry weight table and steps through it one packet at a time, once or in a continuous loop.
- Snoops the multiplier's input stream handshake (tvalid/tready/tlast) and never drives the stream itself.

Parameters:
- WEIGHT_WIDTH, 8, multiplier weight magnitude width; each lane weight is WEIGHT_WIDTH+1 bits, matching the multiplier's bWeight port.
- NUM_CH, 4, number of multiplier instances (channels) driven.
- TABLE_DEPTH, 16, number of weight-set entries.
- IDX_WIDTH, 4, index width, equal to clog2(TABLE_DEPTH).

Ports:
- CLK  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_WIDTH  table write address.
- cfg_wdata  in  NUM_CH*(WEIGHT_WIDTH+1)  weight set; channel c occupies bits [c*(WEIGHT_WIDTH+1) +: WEIGHT_WIDTH+1].
- cfg_len  in  IDX_WIDTH+1  number of entries in the sweep, latched at start.
- cfg_loop  in  1  1 = continuous sweep, 0 = single pass; latched at start.
- cfg_default  in  NUM_CH*(WEIGHT_WIDTH+1)  weight set driven while idle.
- cfg_start  in  1  start pulse.
- cfg_stop  in  1  graceful stop request.
- s_tvalid, s_tready, s_tlast  in  1 each  snooped multiplier input handshake.
- bweight  out  NUM_CH*(WEIGHT_WIDTH+1)  registered weights to the multipliers.
- cur_idx  out  IDX_WIDTH  active table entry.
- busy  out  1  high in RUN or STOPPING.
- done  out  1  one-cycle pulse on sweep completion or stop.
- sweep_cnt  out  16  completed loop passes; saturates at 16'hFFFF.
- wr_err  out  1  one-cycle pulse when a table write is rejected.

Behaviour:
- Reset (resetn=0 at a CLK edge):
  - State goes to IDLE; all outputs go to 0; all table entries clear to 0; latched len and loop clear to 0.
  - Reset mid-sweep aborts immediately; done does not pulse.
- Packet boundary (pb): s_tvalid & s_tready & s_tlast in the same cycle.
- Weight update timing: all weight updates are registered on the pb edge, so the first beat of the next packet sees the new weight. Latency is 0 packets and 1 cycle.
- IDLE:
  - bweight follows cfg_default, registered with 1-cycle latency; cur_idx=0; busy=0.
  - cfg_we writes table[cfg_addr] <= cfg_wdata.
  - cfg_start with cfg_len!=0: latch len=min(cfg_len, TABLE_DEPTH) and loop; bweight <= table[0]; cur_idx <= 0; sweep_cnt <= 0; go to RUN.
  - cfg_start with cfg_len==0: ignored.
  - cfg_start and cfg_stop asserted in the same cycle: stop wins and the start is ignored.
  - cfg_start and cfg_we in the same cycle: the write lands first, so entry 0 can be written and used in that cycle.
- RUN:
  - busy=1.
  - On pb with cur_idx < len-1: cur_idx+1, bweight <= table[cur_idx+1].
  - On pb with cur_idx == len-1 and loop=1: wrap to 0, bweight <= table[0], sweep_cnt+1 (saturating).
  - On pb with cur_idx == len-1 and loop=0: done pulse, go to IDLE, bweight <= cfg_default.
  - cfg_stop: go to STOPPING; the current weights are held.
  - cfg_stop coincident with a pb: the stop takes effect at that boundary (done, IDLE) with no advance.
- STOPPING:
  - Weights are held.
  - The next pb gives a done pulse, IDLE, and bweight <= cfg_default.
  - cfg_start is ignored.
- Busy rules:
  - cfg_we while busy is rejected: table unchanged, wr_err pulses.
  - cfg_start while busy is ignored.
- cfg_addr >= TABLE_DEPTH: the write is rejected and wr_err pulses.
- Table width: the table is flip-flop based; cur_idx and the table read are single-cycle.

Optional Feature:
- Macro: BF_DWELL_EN.
- When defined:
  - Adds input port cfg_dwell (8 bits), latched at start.
  - Each entry is held for max(cfg_dwell,1) packet boundaries before advancing. A dwell counter resets on every advance and on start.
  - The stop and done rules apply at the next pb, regardless of the dwell count.
- When undefined: dwell is fixed at 1 packet per entry and there is no cfg_dwell port.

Test Plan:
- Write entries 0..2 = 9'h010/9'h020/9'h040 (all channels), len=3, loop=0, start, then 3 packets of 4 beats -> bweight is 010, 020, 040 across packets, changing on the cycle after each tlast; done after the 3rd tlast; bweight=cfg_default.
- Same table, loop=1, 7 packets -> index sequence 0,1,2,0,1,2,0; sweep_cnt=2; busy stays 1.
- In RUN, assert cfg_stop mid-packet 2 -> weight held until that packet's tlast; then done pulse, IDLE, no advance.
- cfg_we during RUN to address 1 -> wr_err pulses and entry 1 keeps its value on the next pass; cfg_start during RUN is ignored.
- cfg_len=0 start -> stays IDLE; cfg_len=20 -> clamps to 16 and wraps after index 15; resetn low mid-sweep -> all outputs 0 on the next edge with no done pulse.
- BF_DWELL_EN with dwell=3, len=2 -> each weight spans 3 packets; dwell=0 behaves as 1.
